mem_bus_arbiter: RTL and testbench

- Shares one memory port between the fetch stage (instruction reads) and the load/store stage (data reads and writes).
- Sits between those stage units and the memory model, below the core top level.
- Accepts one transaction at a time with valid/ready handshakes and round-robin arbitration.
- Routes the single response back to whichever requester owns the transaction.

---
 rtl/mem_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (IFU) and load/store (LSU).
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ifu_req_valid,
    output logic                    ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   ifu_addr,
    output logic                    ifu_rsp_valid,
    output logic [DATA_WIDTH-1:0]   ifu_rsp_data,
    output logic                    ifu_rsp_err,
    input  logic                    lsu_req_valid,
    output logic                    lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr,
    input  logic                    lsu_wen,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata,
    input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
    output logic                    lsu_rsp_valid,
    output logic [DATA_WIDTH-1:0]   lsu_rsp_data,
    output logic                    lsu_rsp_err,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_wen,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_data
);
    localparam int MaskW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t                  state, stateNext;
    logic                    owner;      // 0 = IFU, 1 = LSU
    logic                    lastGrant;  // 0 = IFU, 1 = LSU
    logic [ADDR_WIDTH-1:0]   addrQ;
    logic                    wenQ;
    logic [DATA_WIDTH-1:0]   wdataQ;
    logic [MaskW-1:0]        wmaskQ;
    logic                    grantIfu, grantLsu;
    logic                    rspFire, timeoutHit;
    logic [DATA_WIDTH-1:0]   rspData;

`ifdef ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] toCnt;

    // Held at zero while idle so it starts from zero on entering REQ.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            toCnt <= '0;
        end else if (toCnt != CntW'(TIMEOUT_CYCLES)) begin
            toCnt <= toCnt + 1'b1;
        end
    end

    assign timeoutHit = (state != IDLE) && (toCnt == CntW'(TIMEOUT_CYCLES))
                        && !(state == RSP && mem_rsp_valid);
`else
    assign timeoutHit = 1'b0;
`endif

    always_comb begin
        stateNext = state;
        grantIfu  = 1'b0;
        grantLsu  = 1'b0;
        case (state)
            IDLE: begin
                grantIfu = ifu_req_valid && (!lsu_req_valid || lastGrant);
                grantLsu = lsu_req_valid && !grantIfu;
                if (grantIfu || grantLsu) stateNext = REQ;
            end
            REQ: begin
                if (timeoutHit)         stateNext = IDLE;
                else if (mem_req_ready) stateNext = RSP;
            end
            RSP: begin
                if (mem_rsp_valid || timeoutHit) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Handshake outputs are suppressed while reset is held.
    assign ifu_req_ready = grantIfu && !rst;
    assign lsu_req_ready = grantLsu && !rst;
    assign mem_req_valid = (state == REQ) && !timeoutHit && !rst;
    assign rspFire       = ((state == RSP && mem_rsp_valid) || timeoutHit) && !rst;
    assign ifu_rsp_valid = rspFire && !owner;
    assign lsu_rsp_valid = rspFire && owner;
    assign rspData       = (timeoutHit || wenQ) ? '0 : mem_rsp_data;
    assign ifu_rsp_data  = ifu_rsp_valid ? rspData : '0;
    assign lsu_rsp_data  = lsu_rsp_valid ? rspData : '0;
    assign ifu_rsp_err   = ifu_rsp_valid && timeoutHit;
    assign lsu_rsp_err   = lsu_rsp_valid && timeoutHit;

    assign mem_addr  = addrQ;
    assign mem_wen   = wenQ;
    assign mem_wdata = wdataQ;
    assign mem_wmask = wmaskQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            lastGrant <= 1'b1;
            addrQ     <= '0;
            wenQ      <= 1'b0;
            wdataQ    <= '0;
            wmaskQ    <= '0;
        end else begin
            state <= stateNext;
            if (grantIfu) begin
                owner     <= 1'b0;
                lastGrant <= 1'b0;
                addrQ     <= ifu_addr;
                wenQ      <= 1'b0;
                wdataQ    <= '0;
                wmaskQ    <= '0;
            end else if (grantLsu) begin
                owner     <= 1'b1;
                lastGrant <= 1'b1;
                addrQ     <= lsu_addr;
                wenQ      <= lsu_wen;
                wdataQ    <= lsu_wdata;
                wmaskQ    <= lsu_wmask;
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a randomized
// transaction sequence checked against a transaction-level reference model.
module tb_mem_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ifu_req_valid = 1'b0, ifu_req_ready;
    logic [AW-1:0] ifu_addr = '0;
    logic          ifu_rsp_valid, ifu_rsp_err;
    logic [DW-1:0] ifu_rsp_data;
    logic          lsu_req_valid = 1'b0, lsu_req_ready;
    logic [AW-1:0] lsu_addr = '0;
    logic          lsu_wen = 1'b0;
    logic [DW-1:0] lsu_wdata = '0;
    logic [MW-1:0] lsu_wmask = '0;
    logic          lsu_rsp_valid, lsu_rsp_err;
    logic [DW-1:0] lsu_rsp_data;
    logic          mem_req_valid, mem_req_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;
    logic          mem_rsp_valid = 1'b0;
    logic [DW-1:0] mem_rsp_data = '0;

    int nChecks = 0;
    int nFails  = 0;

    mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    always #5 clk = ~clk;

    // Drive-only helper: leaves the bench at a negedge with rst just released.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; mem_rsp_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        nChecks++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid} !== 5'b0) begin
            nFails++;
            $display("FAIL reset_handshakes: got rdy=%b%b memv=%b rspv=%b%b, need all 0",
                     ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid);
        end
        nChecks++;
        if (mem_addr !== '0 || mem_wen !== 1'b0 || mem_wdata !== '0 || mem_wmask !== '0 ||
            ifu_rsp_data !== '0 || lsu_rsp_data !== '0) begin
            nFails++;
            $display("FAIL reset_fields: got addr=%h wen=%b wdata=%h wmask=%h, need 0", mem_addr, mem_wen, mem_wdata, mem_wmask);
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_rsp_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        #1;
        nChecks++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid} !== 5'b0) begin
            nFails++;
            $display("FAIL idle_after_reset: got outputs active, need all 0");
        end
    endtask

    task automatic test_ifu_read();
        do_reset();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; mem_req_ready = 1'b1;
        #1;
        nChecks++;
        if (ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin
            nFails++;
            $display("FAIL ifu_read_c0: got irdy=%b lrdy=%b memv=%b, need 1 0 0", ifu_req_ready, lsu_req_ready, mem_req_valid);
        end
        @(negedge clk);
        ifu_req_valid = 1'b0; ifu_addr = 32'h1234_5678;
        #1;
        nChecks++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_wen !== 1'b0 || mem_wmask !== '0) begin
            nFails++;
            $display("FAIL ifu_read_c1: got memv=%b addr=%h wen=%b, need 1 80000000 0", mem_req_valid, mem_addr, mem_wen);
        end
        @(negedge clk);
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0413;
        #1;
        nChecks++;
        if (ifu_rsp_valid !== 1'b1 || ifu_rsp_data !== 32'h0000_0413 || ifu_rsp_err !== 1'b0 || lsu_rsp_valid !== 1'b0) begin
            nFails++;
            $display("FAIL ifu_read_c2: got iv=%b data=%h err=%b lv=%b, need 1 00000413 0 0",
                     ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err, lsu_rsp_valid);
        end
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        #1;
        nChecks++;
        if (ifu_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            nFails++;
            $display("FAIL ifu_read_c3: got iv=%b memv=%b, need 0 0", ifu_rsp_valid, mem_req_valid);
        end
    endtask

    task automatic test_contention();
        do_reset();
        ifu_req_valid = 1'b1; ifu_addr = 32'h0000_1000;
        lsu_req_valid = 1'b1; lsu_addr = 32'h0000_2000; lsu_wen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
            #1;
            nChecks++;
            if (ifu_req_ready !== (i % 2 == 0) || lsu_req_ready !== (i % 2 == 1)) begin
                nFails++;
                $display("FAIL contention_grant[%0d]: got irdy=%b lrdy=%b, need %s", i,
                         ifu_req_ready, lsu_req_ready, (i % 2 == 0) ? "IFU" : "LSU");
            end
            @(negedge clk);
            #1;
            nChecks++;
            if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0 || mem_req_valid !== 1'b1) begin
                nFails++;
                $display("FAIL contention_busy[%0d]: got irdy=%b lrdy=%b memv=%b, need 0 0 1",
                         i, ifu_req_ready, lsu_req_ready, mem_req_valid);
            end
            @(negedge clk);
            mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hA000_0000 + i;
            #1;
            nChecks++;
            if (ifu_rsp_valid !== (i % 2 == 0) || lsu_rsp_valid !== (i % 2 == 1)) begin
                nFails++;
                $display("FAIL contention_route[%0d]: got iv=%b lv=%b", i, ifu_rsp_valid, lsu_rsp_valid);
            end
            @(negedge clk);
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_rsp_valid = 1'b0;
    endtask

    task automatic test_lsu_write();
        do_reset();
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF; mem_req_ready = 1'b0;
        #1;
        nChecks++;
        if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b0) begin
            nFails++;
            $display("FAIL lsu_write_accept: got lrdy=%b irdy=%b, need 1 0", lsu_req_ready, ifu_req_ready);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            lsu_req_valid = 1'b0; lsu_addr = $urandom(); lsu_wdata = $urandom(); lsu_wmask = 4'h0;
            mem_req_ready = (k == 3);
            #1;
            nChecks++;
            if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_1000 || mem_wen !== 1'b1 ||
                mem_wdata !== 32'hDEAD_BEEF || mem_wmask !== 4'hF) begin
                nFails++;
                $display("FAIL lsu_write_hold[%0d]: got v=%b addr=%h wen=%b wdata=%h mask=%h, need 1 80001000 1 deadbeef f",
                         k, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask);
            end
        end
        @(negedge clk);
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
        #1;
        nChecks++;
        if (lsu_rsp_valid !== 1'b1 || lsu_rsp_data !== '0 || ifu_rsp_valid !== 1'b0) begin
            nFails++;
            $display("FAIL lsu_write_rsp: got lv=%b data=%h iv=%b, need 1 00000000 0", lsu_rsp_valid, lsu_rsp_data, ifu_rsp_valid);
        end
        @(negedge clk);
        mem_rsp_valid = 1'b0;
    endtask

    task automatic test_stray_idle();
        do_reset();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hFFFF_FFFF;
        #1;
        nChecks++;
        if (ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            nFails++;
            $display("FAIL stray_idle: got iv=%b lv=%b memv=%b, need 0 0 0", ifu_rsp_valid, lsu_rsp_valid, mem_req_valid);
        end
        @(negedge clk);
        mem_rsp_valid = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 32'h0000_0040;
        #1;
        nChecks++;
        if (ifu_req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
            nFails++;
            $display("FAIL stray_idle_state: got irdy=%b memv=%b, need 1 0", ifu_req_ready, mem_req_valid);
        end
        @(negedge clk);
        ifu_req_valid = 1'b0;
    endtask

    task automatic test_reset_in_rsp();
        do_reset();
        lsu_req_valid = 1'b1; lsu_addr = 32'h0000_3000; lsu_wen = 1'b0; lsu_wmask = 4'h3;
        mem_req_ready = 1'b1;
        @(negedge clk);
        lsu_req_valid = 1'b0;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        nChecks++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid} !== 5'b0 ||
            mem_addr !== '0 || mem_wmask !== '0) begin
            nFails++;
            $display("FAIL reset_in_rsp: got memv=%b addr=%h mask=%h, need 0 0 0", mem_req_valid, mem_addr, mem_wmask);
        end
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555_AAAA;
        #1;
        nChecks++;
        if (ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0) begin
            nFails++;
            $display("FAIL late_rsp_ignored: got iv=%b lv=%b, need 0 0", ifu_rsp_valid, lsu_rsp_valid);
        end
        @(negedge clk);
        mem_rsp_valid = 1'b0;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        ifu_req_valid = 1'b1; ifu_addr = 32'h0000_0100; mem_req_ready = 1'b0;
        @(negedge clk);
        ifu_req_valid = 1'b0;
        for (int k = 0; k <= TO; k++) begin
            #1;
            nChecks++;
            if (ifu_rsp_valid !== (k == TO) || ifu_rsp_err !== (k == TO) ||
                (k == TO && ifu_rsp_data !== '0) || lsu_rsp_valid !== 1'b0) begin
                nFails++;
                $display("FAIL timeout[%0d]: got iv=%b err=%b data=%h", k, ifu_rsp_valid, ifu_rsp_err, ifu_rsp_data);
            end
            @(negedge clk);
        end
        lsu_req_valid = 1'b1; lsu_addr = 32'h0000_0200; lsu_wen = 1'b0;
        #1;
        nChecks++;
        if (lsu_req_ready !== 1'b1) begin
            nFails++;
            $display("FAIL timeout_next_accept: got lrdy=%b, need 1", lsu_req_ready);
        end
        @(negedge clk);
        lsu_req_valid = 1'b0;
    endtask
`endif

    // Reference model: pending requests per side, round-robin pointer, and a
    // record of the accepted transaction; the bench plays the memory.
    task automatic test_random();
        bit            ifuPend, lsuPend, winL, lastG, ok;
        logic [AW-1:0] iA, lA, eA;
        logic [DW-1:0] lD, eD, rd;
        logic          lW, eW;
        logic [MW-1:0] lM, eM;
        int            d1, d2;
        do_reset();
        ifuPend = 0; lsuPend = 0; lastG = 1;
        iA = '0; lA = '0; lD = '0; lW = 0; lM = '0;
        for (int t = 0; t < 40; t++) begin
            mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
            if (!ifuPend && !lsuPend && $urandom_range(0, 3) == 0) begin
                ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
                mem_rsp_valid = 1'b1; mem_rsp_data = $urandom();
                #1;
                nChecks++;
                if (ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0 || ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin
                    nFails++;
                    $display("FAIL rand_idle[%0d]: got iv=%b lv=%b", t, ifu_rsp_valid, lsu_rsp_valid);
                end
                @(negedge clk);
                mem_rsp_valid = 1'b0;
            end
            if (!ifuPend && $urandom_range(0, 1) == 1) begin ifuPend = 1; iA = $urandom(); end
            if (!lsuPend && $urandom_range(0, 1) == 1) begin
                lsuPend = 1; lA = $urandom(); lD = $urandom(); lW = 1'($urandom_range(0, 1)); lM = 4'($urandom());
            end
            if (!ifuPend && !lsuPend) begin ifuPend = 1; iA = $urandom(); end
            ifu_req_valid = ifuPend; ifu_addr = iA;
            lsu_req_valid = lsuPend; lsu_addr = lA; lsu_wdata = lD; lsu_wen = lW; lsu_wmask = lM;
            winL = lsuPend && (!ifuPend || !lastG);
            #1;
            nChecks++;
            if (ifu_req_ready !== !winL || lsu_req_ready !== winL) begin
                nFails++;
                $display("FAIL rand_grant[%0d]: got irdy=%b lrdy=%b, need %b %b", t, ifu_req_ready, lsu_req_ready, !winL, winL);
            end
            if (winL) begin eA = lA; eW = lW; eD = lD; eM = lM; lsuPend = 0; end
            else      begin eA = iA; eW = 0;  eD = '0; eM = '0; ifuPend = 0; end
            lastG = winL;
            d1 = $urandom_range(0, 3);
            d2 = $urandom_range(0, 3);
            for (int k = 0; k <= d1; k++) begin
                @(negedge clk);
                ifu_req_valid = ifuPend; lsu_req_valid = lsuPend;
                mem_req_ready = (k == d1); mem_rsp_valid = 1'($urandom_range(0, 1)); mem_rsp_data = $urandom();
                #1;
                ok = mem_req_valid === 1'b1 && mem_addr === eA && mem_wen === eW && mem_wmask === eM &&
                     (!eW || mem_wdata === eD) && ifu_rsp_valid === 1'b0 && lsu_rsp_valid === 1'b0 &&
                     ifu_req_ready === 1'b0 && lsu_req_ready === 1'b0;
                nChecks++;
                if (!ok) begin
                    nFails++;
                    $display("FAIL rand_req[%0d.%0d]: got v=%b addr=%h wen=%b mask=%h, need 1 %h %b %h",
                             t, k, mem_req_valid, mem_addr, mem_wen, mem_wmask, eA, eW, eM);
                end
            end
            for (int k = 0; k <= d2; k++) begin
                @(negedge clk);
                mem_req_ready = 1'b0; mem_rsp_valid = (k == d2); rd = $urandom(); mem_rsp_data = rd;
                #1;
                ok = mem_req_valid === 1'b0 && ifu_req_ready === 1'b0 && lsu_req_ready === 1'b0 &&
                     ifu_rsp_valid === (k == d2 && !winL) && lsu_rsp_valid === (k == d2 && winL) &&
                     (!ifu_rsp_valid || ifu_rsp_data === (eW ? '0 : rd)) &&
                     (!lsu_rsp_valid || lsu_rsp_data === (eW ? '0 : rd)) &&
                     ifu_rsp_err === 1'b0 && lsu_rsp_err === 1'b0;
                nChecks++;
                if (!ok) begin
                    nFails++;
                    $display("FAIL rand_rsp[%0d.%0d]: got iv=%b lv=%b idata=%h ldata=%h memdata=%h wen=%b",
                             t, k, ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_data, lsu_rsp_data, rd, eW);
                end
            end
            @(negedge clk);
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_rsp_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_contention();
        test_lsu_write();
        test_stray_idle();
        test_reset_in_rsp();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
